// File: rtl/wb_arb_pkg.sv
// Shared encodings and defaults for the two-master Wishbone arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int PRIORITY_RR    = 0;
  localparam int PRIORITY_FIXED = 1;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hBADB_AD00;
endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags the cycle that must be
// terminated because the slave never acknowledged.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic grant_change_i,
  output logic timeout_o
);
  localparam bit          EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  // cnt holds completed stalled cycles, so matching LAST means the current
  // cycle is stalled cycle number TIMEOUT_CYCLES.
  assign timeout_o = EN && stb_i && !ack_i && (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt <= '0;
    else if (grant_change_i || !stb_i || ack_i || timeout_o)
      cnt <= '0;
    else
      cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin or fixed priority, grant held for
// a whole cyc, with a watchdog that terminates unacknowledged strobes.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_SEL_WIDTH   = 4,
  parameter int                       PRIORITY_MODE  = PRIORITY_RR,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA   = WB_DATA_WIDTH'(TIMEOUT_DATA_DEFAULT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_m0_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_m0_sel_i,
  input  logic                     wb_m0_we_i,
  input  logic                     wb_m0_stb_i,
  input  logic                     wb_m0_cyc_i,
  output logic                     wb_m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_m0_data_o,
  input  logic [WB_ADDR_WIDTH-1:0] wb_m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_m1_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_m1_sel_i,
  input  logic                     wb_m1_we_i,
  input  logic                     wb_m1_stb_i,
  input  logic                     wb_m1_cyc_i,
  output logic                     wb_m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_m1_data_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_s_data_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_s_sel_o,
  output logic                     wb_s_we_o,
  output logic                     wb_s_stb_o,
  output logic                     wb_s_cyc_o,
  input  logic                     wb_s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_s_data_i,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);
  arb_state_e state, state_nxt;
  logic       last_grant;  // 1: master 1 was granted most recently
  logic       arb_en;
  logic       g0, g1;
  logic       stb_sel;
  logic       timeout;
  logic       ack_any;
  logic [WB_DATA_WIDTH-1:0] rdata;

  assign g0 = (state == GNT0);
  assign g1 = (state == GNT1);

  always_comb begin
    state_nxt = state;
    arb_en    = (state == IDLE) || (g0 && !wb_m0_cyc_i) || (g1 && !wb_m1_cyc_i);
    if (arb_en) begin
      if (wb_m0_cyc_i && wb_m1_cyc_i)
        state_nxt = (PRIORITY_MODE == PRIORITY_FIXED || !last_grant) ? GNT1 : GNT0;
      else if (wb_m0_cyc_i)
        state_nxt = GNT0;
      else if (wb_m1_cyc_i)
        state_nxt = GNT1;
      else
        state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && state_nxt != IDLE)
        last_grant <= (state_nxt == GNT1);
    end
  end

  always_comb begin
    wb_s_addr_o = '0;
    wb_s_data_o = '0;
    wb_s_sel_o  = '0;
    wb_s_we_o   = 1'b0;
    wb_s_cyc_o  = 1'b0;
    stb_sel     = 1'b0;
    case (state)
      GNT0: begin
        wb_s_addr_o = wb_m0_addr_i;
        wb_s_data_o = wb_m0_data_i;
        wb_s_sel_o  = wb_m0_sel_i;
        wb_s_we_o   = wb_m0_we_i;
        wb_s_cyc_o  = wb_m0_cyc_i;
        stb_sel     = wb_m0_stb_i;
      end
      GNT1: begin
        wb_s_addr_o = wb_m1_addr_i;
        wb_s_data_o = wb_m1_data_i;
        wb_s_sel_o  = wb_m1_sel_i;
        wb_s_we_o   = wb_m1_we_i;
        wb_s_cyc_o  = wb_m1_cyc_i;
        stb_sel     = wb_m1_stb_i;
      end
      default: ;
    endcase
  end

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stb_i          (stb_sel),
    .ack_i          (wb_s_ack_i),
    .grant_change_i (state_nxt != state),
    .timeout_o      (timeout)
  );

  // A terminated strobe must not also reach the slave; acks are suppressed
  // while reset abandons the transfer.
  assign wb_s_stb_o   = stb_sel & ~timeout;
  assign ack_any      = (wb_s_ack_i | timeout) & ~rst_i;
  assign rdata        = timeout ? TIMEOUT_DATA : wb_s_data_i;
  assign wb_m0_ack_o  = g0 & ack_any;
  assign wb_m1_ack_o  = g1 & ack_any;
  assign wb_m0_data_o = g0 ? rdata : '0;
  assign wb_m1_data_o = g1 ? rdata : '0;
  assign grant_o      = {g1, g0};
  assign timeout_o    = timeout & ~rst_i;
endmodule

// File: tb/tb_wb_arbiter.sv
// Cycle-table bench for wb_arbiter: round-robin and fixed-priority instances
// share master/slave stimulus; expected outputs go through a scoreboard queue.
module tb_wb_arbiter;
  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR = 32'h0000_0200;
  localparam logic [31:0] M0_WDAT = 32'h0000_1111;
  localparam logic [31:0] M1_WDAT = 32'h2222_0000;
  localparam logic [3:0]  M0_SEL  = 4'hF;
  localparam logic [3:0]  M1_SEL  = 4'h3;
  localparam logic [31:0] BAD     = 32'hBADB_AD00;

  typedef struct {
    logic [5:0] in;   // {rst, c0, s0, c1, s1, ack}
    logic [1:0] gnt;
    logic [4:0] out;  // {scyc, sstb, a0, a1, to}
    bit         fx;   // check the fixed-priority instance
  } vec_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_sel;
    logic        s_we;
    logic        s_cyc;
    logic        s_stb;
    logic        a0;
    logic [31:0] d0;
    logic        a1;
    logic [31:0] d1;
    logic        to;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c0 = 0, s0 = 0, c1 = 0, s1 = 0, sack = 0;
  logic [31:0] sdat = '0;

  logic        a0_r, a1_r, scyc_r, sstb_r, swe_r, to_r;
  logic [31:0] d0_r, d1_r, saddr_r, sdata_r;
  logic [3:0]  ssel_r;
  logic [1:0]  gnt_r;
  logic        a0_f, a1_f, scyc_f, sstb_f, swe_f, to_f;
  logic [31:0] d0_f, d1_f, saddr_f, sdata_f;
  logic [3:0]  ssel_f;
  logic [1:0]  gnt_f;

  int checks = 0;
  int failures = 0;
  out_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  wb_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_m0_addr_i(M0_ADDR), .wb_m0_data_i(M0_WDAT), .wb_m0_sel_i(M0_SEL), .wb_m0_we_i(1'b0),
    .wb_m0_stb_i(s0), .wb_m0_cyc_i(c0), .wb_m0_ack_o(a0_r), .wb_m0_data_o(d0_r),
    .wb_m1_addr_i(M1_ADDR), .wb_m1_data_i(M1_WDAT), .wb_m1_sel_i(M1_SEL), .wb_m1_we_i(1'b1),
    .wb_m1_stb_i(s1), .wb_m1_cyc_i(c1), .wb_m1_ack_o(a1_r), .wb_m1_data_o(d1_r),
    .wb_s_addr_o(saddr_r), .wb_s_data_o(sdata_r), .wb_s_sel_o(ssel_r), .wb_s_we_o(swe_r),
    .wb_s_stb_o(sstb_r), .wb_s_cyc_o(scyc_r), .wb_s_ack_i(sack), .wb_s_data_i(sdat),
    .grant_o(gnt_r), .timeout_o(to_r)
  );

  wb_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut_fx (
    .clk_i(clk), .rst_i(rst),
    .wb_m0_addr_i(M0_ADDR), .wb_m0_data_i(M0_WDAT), .wb_m0_sel_i(M0_SEL), .wb_m0_we_i(1'b0),
    .wb_m0_stb_i(s0), .wb_m0_cyc_i(c0), .wb_m0_ack_o(a0_f), .wb_m0_data_o(d0_f),
    .wb_m1_addr_i(M1_ADDR), .wb_m1_data_i(M1_WDAT), .wb_m1_sel_i(M1_SEL), .wb_m1_we_i(1'b1),
    .wb_m1_stb_i(s1), .wb_m1_cyc_i(c1), .wb_m1_ack_o(a1_f), .wb_m1_data_o(d1_f),
    .wb_s_addr_o(saddr_f), .wb_s_data_o(sdata_f), .wb_s_sel_o(ssel_f), .wb_s_we_o(swe_f),
    .wb_s_stb_o(sstb_f), .wb_s_cyc_o(scyc_f), .wb_s_ack_i(sack), .wb_s_data_i(sdat),
    .grant_o(gnt_f), .timeout_o(to_f)
  );

  function automatic void add(input logic [5:0] in, input logic [1:0] g,
                              input logic [4:0] out, input bit fx);
    vec_t v;
    v.in = in; v.gnt = g; v.out = out; v.fx = fx;
    tbl.push_back(v);
  endfunction

  function automatic out_t model(input vec_t r, input logic [31:0] sd);
    out_t e;
    logic [31:0] rd;
    e = '0;
    rd = r.out[0] ? BAD : sd;
    e.gnt = r.gnt;
    {e.s_cyc, e.s_stb, e.a0, e.a1, e.to} = r.out;
    if (r.gnt == 2'b01) begin
      e.s_addr = M0_ADDR; e.s_data = M0_WDAT; e.s_sel = M0_SEL; e.s_we = 1'b0; e.d0 = rd;
    end else if (r.gnt == 2'b10) begin
      e.s_addr = M1_ADDR; e.s_data = M1_WDAT; e.s_sel = M1_SEL; e.s_we = 1'b1; e.d1 = rd;
    end
    return e;
  endfunction

  function automatic out_t cap(input bit fx);
    out_t a;
    if (fx)
      a = '{gnt_f, saddr_f, sdata_f, ssel_f, swe_f, scyc_f, sstb_f, a0_f, d0_f, a1_f, d1_f, to_f};
    else
      a = '{gnt_r, saddr_r, sdata_r, ssel_r, swe_r, scyc_r, sstb_r, a0_r, d0_r, a1_r, d1_r, to_r};
    return a;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [5:0] in, input logic [31:0] sd);
    @(posedge clk);
    #1;
    {rst, c0, s0, c1, s1, sack} = in;
    sdat = sd;
  endtask

  initial begin
    out_t e, a;
    int n;
    bit seen;
    // Round-robin instance: single read, contention, locked transfer,
    // watchdog, same-cycle ack, reset mid-transfer.
    add(6'b1_00_00_0, 2'b00, 5'b00000, 0);  // reset state
    add(6'b0_11_00_0, 2'b00, 5'b00000, 0);  // CPU raises cyc at 0x100
    add(6'b0_11_00_0, 2'b01, 5'b11000, 0);
    add(6'b0_11_00_0, 2'b01, 5'b11000, 0);
    add(6'b0_11_00_1, 2'b01, 5'b11100, 0);  // slave ack -> CPU data
    add(6'b0_00_00_0, 2'b01, 5'b00000, 0);
    add(6'b0_00_00_0, 2'b00, 5'b00000, 0);
    add(6'b1_00_00_0, 2'b00, 5'b00000, 0);  // reset restores last_grant
    add(6'b0_11_11_0, 2'b00, 5'b00000, 0);  // simultaneous requests
    add(6'b0_11_11_0, 2'b01, 5'b11000, 0);  // CPU wins first tie
    add(6'b0_11_11_1, 2'b01, 5'b11100, 0);
    add(6'b0_00_11_0, 2'b01, 5'b00000, 0);  // CPU releases
    add(6'b0_00_11_1, 2'b10, 5'b11010, 0);  // handover, no idle cycle
    add(6'b0_00_00_0, 2'b10, 5'b00000, 0);
    add(6'b0_11_11_0, 2'b00, 5'b00000, 0);  // repeat contention
    add(6'b0_11_11_1, 2'b01, 5'b11100, 0);  // goes to CPU again
    add(6'b0_00_00_0, 2'b01, 5'b00000, 0);
    add(6'b0_00_00_0, 2'b00, 5'b00000, 0);
    add(6'b0_00_11_0, 2'b00, 5'b00000, 0);  // locked transfer by master 1
    add(6'b0_11_11_1, 2'b10, 5'b11010, 0);
    add(6'b0_10_10_0, 2'b10, 5'b10000, 0);
    add(6'b0_10_11_1, 2'b10, 5'b11010, 0);
    add(6'b0_10_10_0, 2'b10, 5'b10000, 0);
    add(6'b0_10_11_1, 2'b10, 5'b11010, 0);
    add(6'b0_11_00_0, 2'b10, 5'b00000, 0);  // master 1 drops cyc
    for (int k = 0; k < 7; k++)
      add(6'b0_11_00_0, 2'b01, 5'b11000, 0);  // stalled cycles 1..7
    add(6'b0_11_00_0, 2'b01, 5'b10101, 0);  // 8th: forced termination
    for (int k = 0; k < 7; k++)
      add(6'b0_11_00_0, 2'b01, 5'b11000, 0);
    add(6'b0_11_00_1, 2'b01, 5'b11100, 0);  // ack on the 8th wins
    add(6'b0_11_00_0, 2'b01, 5'b11000, 0);
    add(6'b0_11_00_0, 2'b01, 5'b11000, 0);
    add(6'b1_11_00_0, 2'b01, 5'b11000, 0);  // reset mid-transfer
    add(6'b0_11_00_0, 2'b00, 5'b00000, 0);  // bus abandoned, no ack
    add(6'b0_00_00_0, 2'b01, 5'b00000, 0);
    add(6'b0_00_00_0, 2'b00, 5'b00000, 0);
    // Fixed-priority instance.
    add(6'b1_00_00_0, 2'b00, 5'b00000, 1);
    add(6'b0_11_11_0, 2'b00, 5'b00000, 1);
    add(6'b0_11_11_0, 2'b10, 5'b11000, 1);  // master 1 wins
    add(6'b0_11_11_1, 2'b10, 5'b11010, 1);  // CPU sees no ack
    add(6'b0_11_11_0, 2'b10, 5'b11000, 1);
    add(6'b0_11_00_0, 2'b10, 5'b00000, 1);
    add(6'b0_11_00_1, 2'b01, 5'b11100, 1);
    add(6'b0_00_00_0, 2'b01, 5'b00000, 1);
    add(6'b0_00_00_0, 2'b00, 5'b00000, 1);

    foreach (tbl[k]) begin
      logic [31:0] sd;
      sd = 32'h5A00_0000 | 32'(k);
      drive(tbl[k].in, sd);
      exp_q.push_back(model(tbl[k], sd));
      @(negedge clk);
      e = exp_q.pop_front();
      a = cap(tbl[k].fx);
      check($sformatf("row%0d", k), 192'(a), 192'(e));
    end

    // Watchdog on master 1, bounded wait for the pulse.
    n = 0;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      drive(6'b0_00_11_0, 32'h1234_5678);
      @(negedge clk);
      if (to_r) begin
        seen = 1;
        n = k;
        check("wd_m1_ack", 192'(a1_r), 192'(1'b1));
        check("wd_m1_data", 192'(d1_r), 192'(BAD));
        check("wd_s_stb", 192'(sstb_r), 192'(1'b0));
      end
    end
    check("wd_seen", 192'(seen), 192'(1'b1));
    check("wd_cycle", 192'(n), 192'(9));  // 1 grant cycle + 8 stalled
    drive(6'b0_00_11_0, 32'h1234_5678);
    @(negedge clk);
    check("wd_single_pulse", 192'(to_r), 192'(1'b0));
    drive(6'b0_00_00_0, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
